// File: rtl/hgcal_input_quantizer.sv
// rtl/hgcal_input_quantizer.sv - quantizes raw HGCAL cell samples and packs them into double-buffered frames
module hgcal_input_quantizer #(
    parameter int N_INPUTS = 48,
    parameter int IN_W     = 8,
    parameter int Q_W      = 2,
    parameter int SHIFT    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [IN_W-1:0]         s_data,
    input  logic                    s_first,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [N_INPUTS*Q_W-1:0] m_data,
    output logic                    sync_err
);

    localparam int FW    = N_INPUTS * Q_W;
    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [IN_W-1:0] SAT_WIDE = IN_W'((1 << Q_W) - 1);
    localparam logic [Q_W-1:0]  SAT_CODE = Q_W'((1 << Q_W) - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

    typedef enum logic {FILL, STALL} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [FW-1:0]    acc_q, acc_d;
    logic [FW-1:0]    m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             sync_err_q, sync_err_d;

    logic [IN_W-1:0]  q_shift;
    logic [Q_W-1:0]   code;
    logic             beat;
    logic             resync;
    logic [IDX_W-1:0] eff_idx;
    logic             last;
    logic             out_free;
    logic [FW-1:0]    acc_merged;

    always_comb begin
        q_shift = s_data >> SHIFT;
        code    = (q_shift > SAT_WIDE) ? SAT_CODE : q_shift[Q_W-1:0];
    end

    // A frame-start marker mid-frame restarts the fill at cell 0.
    always_comb begin
        beat     = s_valid && (state_q == FILL);
        resync   = s_first && (idx_q != '0);
        eff_idx  = resync ? '0 : idx_q;
        last     = (eff_idx == LAST_IDX);
        out_free = !m_valid_q || m_ready;
        acc_merged = acc_q;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (eff_idx == IDX_W'(i)) begin
                acc_merged[i*Q_W +: Q_W] = code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            idx_q      <= '0;
            acc_q      <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            sync_err_q <= sync_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (beat && last && !out_free) state_d = STALL;
            STALL:   if (m_ready) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        idx_d      = idx_q;
        acc_d      = acc_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        sync_err_d = 1'b0;
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
        if (state_q == FILL && beat) begin
            acc_d      = acc_merged;
            sync_err_d = resync;
            idx_d      = eff_idx + IDX_W'(1);
            if (last) begin
                idx_d = '0;
                if (out_free) begin
                    m_data_d  = acc_merged;
                    m_valid_d = 1'b1;
                end
            end
        end
        // The held frame moves out the moment the downstream slot frees.
        if (state_q == STALL && m_ready) begin
            m_data_d  = acc_q;
            m_valid_d = 1'b1;
            idx_d     = '0;
        end
    end

    always_comb begin
        s_ready  = (state_q == FILL);
        m_valid  = m_valid_q;
        m_data   = m_data_q;
        sync_err = sync_err_q;
    end

endmodule

// File: tb/tb_hgcal_input_quantizer.sv
// tb/tb_hgcal_input_quantizer.sv - directed and randomized self-checking bench for hgcal_input_quantizer
module tb_hgcal_input_quantizer;

    localparam int N  = 48;
    localparam int FW = 96;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s_data;
    logic          s_first;
    logic          m_valid;
    logic          m_ready;
    logic [FW-1:0] m_data;
    logic          sync_err;

    int total = 0;
    int bad   = 0;

    logic [7:0]    smp [N];
    logic [FW-1:0] frame_a;
    logic [FW-1:0] frame_b;
    logic [FW-1:0] all_ones;

    hgcal_input_quantizer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_first  (s_first),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] model_frame();
        logic [FW-1:0] f;
        int c;
        f = '0;
        for (int i = 0; i < N; i++) begin
            c = int'(smp[i]) / 16;
            if (c > 3) c = 3;
            f[i*2 +: 2] = 2'(c);
        end
        return f;
    endfunction

    task automatic randomize_samples();
        for (int i = 0; i < N; i++) smp[i] = 8'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic f);
        int w;
        w = 0;
        while (s_ready !== 1'b1 && w < 100) begin
            step();
            w++;
        end
        if (w == 100) chk("s_ready_timeout", {95'd0, s_ready}, {95'd0, 1'b1});
        s_valid = 1'b1;
        s_data  = d;
        s_first = f;
        step();
        s_valid = 1'b0;
        s_first = 1'b0;
    endtask

    task automatic send_cells(input int n);
        for (int i = 0; i < n; i++) beat(smp[i], i == 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_first = 1'b0;
        m_ready = 1'b1;
        all_ones = '1;
        repeat (3) step();
        rst_n = 1'b1;
        chk("reset_m_valid", {95'd0, m_valid}, '0);
        chk("reset_m_data", m_data, '0);
        chk("reset_sync_err", {95'd0, sync_err}, '0);
        chk("reset_s_ready", {95'd0, s_ready}, {95'd0, 1'b1});

        // Ramp, saturating at 255.
        for (int i = 0; i < N; i++) smp[i] = (i * 16 > 255) ? 8'd255 : 8'(i * 16);
        send_cells(N);
        chk("ramp_valid", {95'd0, m_valid}, {95'd0, 1'b1});
        chk("ramp_low_cells", {90'd0, m_data[5:0]}, {90'd0, 6'b10_01_00});
        chk("ramp_high_cells", {6'd0, m_data[FW-1:6]}, {6'd0, all_ones[FW-1:6]});
        step();
        chk("ramp_valid_drop", {95'd0, m_valid}, '0);

        for (int i = 0; i < N; i++) smp[i] = 8'hFF;
        send_cells(N);
        chk("sat_ff", m_data, all_ones);
        for (int i = 0; i < N; i++) smp[i] = 8'h0F;
        send_cells(N);
        chk("sat_0f", m_data, '0);
        step();

        // Backpressure across two frames.
        m_ready = 1'b0;
        randomize_samples();
        frame_a = model_frame();
        send_cells(N);
        chk("bp_a_valid", {95'd0, m_valid}, {95'd0, 1'b1});
        randomize_samples();
        frame_b = model_frame();
        send_cells(N);
        chk("bp_a_stable", m_data, frame_a);
        chk("bp_stall_ready", {95'd0, s_ready}, '0);
        chk("bp_stall_valid", {95'd0, m_valid}, {95'd0, 1'b1});
        m_ready = 1'b1;
        step();
        chk("bp_b_data", m_data, frame_b);
        chk("bp_b_valid", {95'd0, m_valid}, {95'd0, 1'b1});
        chk("bp_ready_back", {95'd0, s_ready}, {95'd0, 1'b1});
        step();
        chk("bp_drain", {95'd0, m_valid}, '0);

        // Back-to-back: acceptance coincides with the last beat of the next frame.
        m_ready = 1'b0;
        randomize_samples();
        frame_a = model_frame();
        send_cells(N);
        randomize_samples();
        frame_b = model_frame();
        send_cells(N - 1);
        chk("b2b_hold_a", m_data, frame_a);
        m_ready = 1'b1;
        beat(smp[N-1], 1'b0);
        chk("b2b_valid", {95'd0, m_valid}, {95'd0, 1'b1});
        chk("b2b_data", m_data, frame_b);
        step();
        chk("b2b_drain", {95'd0, m_valid}, '0);

        // Resync at idx 20.
        randomize_samples();
        send_cells(20);
        randomize_samples();
        frame_a = model_frame();
        beat(smp[0], 1'b1);
        chk("resync_pulse", {95'd0, sync_err}, {95'd0, 1'b1});
        beat(smp[1], 1'b0);
        chk("resync_pulse_end", {95'd0, sync_err}, '0);
        for (int i = 2; i < N - 1; i++) beat(smp[i], 1'b0);
        chk("resync_no_early", {95'd0, m_valid}, '0);
        beat(smp[N-1], 1'b0);
        chk("resync_valid", {95'd0, m_valid}, {95'd0, 1'b1});
        chk("resync_data", m_data, frame_a);
        step();

        // Random frames with idle gaps.
        for (int f = 0; f < 4; f++) begin
            randomize_samples();
            frame_a = model_frame();
            for (int i = 0; i < N; i++) begin
                repeat ($urandom_range(0, 2)) step();
                beat(smp[i], i == 0);
            end
            chk($sformatf("rand_valid_%0d", f), {95'd0, m_valid}, {95'd0, 1'b1});
            chk($sformatf("rand_data_%0d", f), m_data, frame_a);
        end
        step();

        // Reset during stall.
        m_ready = 1'b0;
        randomize_samples();
        send_cells(N);
        randomize_samples();
        send_cells(N);
        chk("rst_pre_stall", {95'd0, s_ready}, '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", {95'd0, m_valid}, '0);
        chk("rst_async_data", m_data, '0);
        step();
        rst_n = 1'b1;
        chk("rst_release_ready", {95'd0, s_ready}, {95'd0, 1'b1});
        m_ready = 1'b1;
        randomize_samples();
        frame_a = model_frame();
        send_cells(N);
        chk("post_rst_data", m_data, frame_a);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
